drum_sample_player: RTL and testbench
=====================================

# drum_sample_player

Playback controller that sits directly upstream of the single-port sample BRAM in the audio path. On a hit trigger it walks the BRAM from address 0 through one stored drum sample, issuing one read per audio-codec ready strobe. It emits a continuous signed sample stream to the mixer: the drum sample while playing, and silence (0) otherwise. It also drives the BRAM address port and holds the BRAM write-enable low.

## Interface
- LOGSIZE, 14: BRAM address width.
- WIDTH, 8: sample width (two's complement, as stored in BRAM).
- SAMPLE_LEN, 16000: number of samples in the drum sound; 1 ≤ SAMPLE_LEN ≤ 2^LOGSIZE.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- ready  in  1  one-cycle audio-rate strobe; consecutive strobes are at least 4 cycles apart.
- trigger  in  1  one-cycle hit pulse.
- velocity  in  2  hit strength, sampled on trigger.
- bram_addr  out  LOGSIZE  BRAM read address.
- bram_we  out  1  constant 0.
- bram_dout  in  WIDTH  BRAM registered read data (1-cycle read latency).
- sample_out  out  WIDTH  signed output sample.
- sample_valid  out  1  one-cycle pulse when sample_out updates.
- playing  out  1  high while a hit is sounding.
- done  out  1  one-cycle pulse after the last sample is emitted.

## Operation
- FSM states:
  - S_WAIT: idle between strobes.
  - S_READ: address held stable; BRAM samples it.
  - S_CAPTURE: bram_dout is valid.
- FSM transitions: S_WAIT→S_READ on ready; S_READ→S_CAPTURE unconditionally; S_CAPTURE→S_WAIT unconditionally.
- bram_addr is the registered pointer ptr; it changes only at the end of S_CAPTURE or on trigger.
- In S_CAPTURE:
  - sample_out <= playing ? scale(bram_dout, vel_q) : 0.
  - sample_valid pulses on the following cycle.
- Pointer advance (only while playing): ptr+1. If ptr == SAMPLE_LEN-1, then ptr <= 0, playing <= 0, and done pulses alongside sample_valid.
- Trigger in S_WAIT: ptr <= 0, playing <= 1, vel_q <= velocity. If ready is in the same cycle, the FSM also moves to S_READ and reads address 0.
- Trigger in S_READ or S_CAPTURE (retrigger):
  - Sets restart_pending and captures velocity.
  - The restart is applied at the end of S_CAPTURE, after the current sample is emitted: ptr <= 0, playing <= 1.
  - The pending restart overrides the end-of-sample wrap, and done does not pulse.
- Retrigger while playing in S_WAIT restarts immediately from address 0.
- ready in S_READ or S_CAPTURE is ignored (protocol violation, no error flag).
- Arithmetic: sample_out is signed. Scaling is an arithmetic right shift; no saturation is needed.

## Timing
- Reset values: state S_WAIT; ptr 0 (so bram_addr 0); sample_out 0; sample_valid 0; playing 0; done 0; vel_q 3; restart_pending 0. bram_we is always 0.
- Latency: ready at cycle t → sample_valid high in cycle t+3 → new sample_out stable from t+3 until the next update.
- sample_valid fires exactly once per accepted ready, playing or not.
- trigger at cycle t in S_WAIT → playing high from t+1.
- Reset mid-playback aborts immediately; the next sample after reset is 0.

## Configuration
- DRUM_VELOCITY_EN defined: sample_out = bram_dout >>> (3 - vel_q), so velocity 3 is full scale and velocity 0 is 1/8 scale.
- DRUM_VELOCITY_EN undefined: sample_out = bram_dout unscaled. The velocity port remains but is ignored, and vel_q is not built.

## Structure
- Package drum_pkg holds:
  - the state typedef (S_WAIT, S_READ, S_CAPTURE);
  - the velocity width constant (2);
  - the full-scale velocity constant (3).
- One sub-module, drum_velocity_scale: a combinational signed shift of WIDTH bits by (3 - vel). It is instantiated only under DRUM_VELOCITY_EN.

## Test plan
- Reset, then ready every 10 cycles with no trigger → sample_valid at t+3 each time, sample_out = 0, bram_addr = 0, playing = 0.
- BRAM preloaded with mem[i] = i[7:0] and SAMPLE_LEN = 4; trigger with velocity 3, then 5 readies:
  - sample_out = 0, 1, 2, 3, then 0;
  - done pulses together with the sample 3 output;
  - playing falls after that output.
- With DRUM_VELOCITY_EN: mem[0] = -64 (0xC0), velocity 1 → first sample_out = -16 (0xF0). Without the macro: 0xC0.
- Retrigger asserted in the S_READ cycle of the sample at address 2 → sample 2 is still output, the next read is address 0, and done does not pulse.
- trigger and ready in the same cycle from idle → bram_addr = 0 during S_READ, and sample_out = mem[0] at t+3.
- reset asserted while at address 2 → the next cycle shows playing = 0, bram_addr = 0, sample_out = 0, and the following ready yields 0.

Source files
------------

// File: rtl/drum_pkg.sv
// ============================================================================
// drum_pkg : shared types and constants for the drum sample player
// Revision : 1.0
// ============================================================================
`default_nettype none

package drum_pkg;

    typedef enum logic [1:0] {
        S_WAIT    = 2'd0,
        S_READ    = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    localparam int                     c_VEL_WIDTH = 2;
    localparam logic [c_VEL_WIDTH-1:0] c_VEL_FULL  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/drum_velocity_scale.sv
// ============================================================================
// drum_velocity_scale : signed sample attenuation by an arithmetic right shift
//                       of (full-scale velocity - vel)
// Revision : 1.0
// ============================================================================
`default_nettype none

module drum_velocity_scale
    import drum_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]       sample_in,
    input  logic [c_VEL_WIDTH-1:0] vel,
    output logic [WIDTH-1:0]       sample_out
);

    logic [c_VEL_WIDTH-1:0] w_shamt;

    assign w_shamt    = c_VEL_FULL - vel;
    assign sample_out = $unsigned($signed(sample_in) >>> w_shamt);

endmodule

`default_nettype wire

// File: rtl/drum_sample_player.sv
// ============================================================================
// drum_sample_player : plays one stored drum sample from BRAM, one read per
//                      codec ready strobe. Optional DRUM_VELOCITY_EN enables
//                      velocity attenuation of the output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module drum_sample_player
    import drum_pkg::*;
#(
    parameter int LOGSIZE    = 14,
    parameter int WIDTH      = 8,
    parameter int SAMPLE_LEN = 16000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ready,
    input  logic                   trigger,
    input  logic [c_VEL_WIDTH-1:0] velocity,
    output logic [LOGSIZE-1:0]     bram_addr,
    output logic                   bram_we,
    input  logic [WIDTH-1:0]       bram_dout,
    output logic [WIDTH-1:0]       sample_out,
    output logic                   sample_valid,
    output logic                   playing,
    output logic                   done
);

    localparam logic [LOGSIZE-1:0] c_LAST = LOGSIZE'(SAMPLE_LEN - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [LOGSIZE-1:0] r_ptr;
    logic               r_playing;
    logic               r_restart_pending;
    logic [WIDTH-1:0]   r_sample;
    logic               r_valid;
    logic               r_done;
    logic [WIDTH-1:0]   w_scaled;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_WAIT:    if (ready) w_next_state = S_READ;
            S_READ:    w_next_state = S_CAPTURE;
            S_CAPTURE: w_next_state = S_WAIT;
            default:   w_next_state = S_WAIT;
        endcase
    end

    // A retrigger arriving during S_CAPTURE itself is folded into the restart
    // applied at the end of that same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr             <= '0;
            r_playing         <= 1'b0;
            r_restart_pending <= 1'b0;
            r_sample          <= '0;
            r_valid           <= 1'b0;
            r_done            <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_WAIT: begin
                    if (trigger) begin
                        r_ptr             <= '0;
                        r_playing         <= 1'b1;
                        r_restart_pending <= 1'b0;
                    end
                end
                S_READ: begin
                    if (trigger) r_restart_pending <= 1'b1;
                end
                S_CAPTURE: begin
                    r_valid  <= 1'b1;
                    r_sample <= r_playing ? w_scaled : '0;
                    if (r_restart_pending || trigger) begin
                        r_ptr             <= '0;
                        r_playing         <= 1'b1;
                        r_restart_pending <= 1'b0;
                    end else if (r_playing) begin
                        if (r_ptr == c_LAST) begin
                            r_ptr     <= '0;
                            r_playing <= 1'b0;
                            r_done    <= 1'b1;
                        end else begin
                            r_ptr <= r_ptr + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DRUM_VELOCITY_EN
    logic [c_VEL_WIDTH-1:0] r_vel_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vel_q <= c_VEL_FULL;
        end else if (trigger) begin
            r_vel_q <= velocity;
        end
    end

    drum_velocity_scale #(
        .WIDTH (WIDTH)
    ) u_scale (
        .sample_in  (bram_dout),
        .vel        (r_vel_q),
        .sample_out (w_scaled)
    );
`else
    logic unused_velocity;

    assign unused_velocity = ^velocity;
    assign w_scaled        = bram_dout;
`endif

    assign bram_addr    = r_ptr;
    assign bram_we      = 1'b0;
    assign sample_out   = r_sample;
    assign sample_valid = r_valid;
    assign playing      = r_playing;
    assign done         = r_done;

endmodule

`default_nettype wire

// File: tb/tb_drum_sample_player.sv
// ============================================================================
// tb_drum_sample_player : directed bench with a per-cycle expectation model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_drum_sample_player;

    localparam int c_LOGSIZE = 6;
    localparam int c_WIDTH   = 8;
    localparam int c_LEN     = 4;
    localparam int c_MAXC    = 1000;
    localparam int c_NOLIT   = -999;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 ready = 1'b0;
    logic                 trigger = 1'b0;
    logic [1:0]           velocity = 2'd3;
    logic [c_LOGSIZE-1:0] bram_addr;
    logic                 bram_we;
    logic [c_WIDTH-1:0]   bram_dout = '0;
    logic [c_WIDTH-1:0]   sample_out;
    logic                 sample_valid;
    logic                 playing;
    logic                 done;

    drum_sample_player #(
        .LOGSIZE    (c_LOGSIZE),
        .WIDTH      (c_WIDTH),
        .SAMPLE_LEN (c_LEN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ready        (ready),
        .trigger      (trigger),
        .velocity     (velocity),
        .bram_addr    (bram_addr),
        .bram_we      (bram_we),
        .bram_dout    (bram_dout),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .playing      (playing),
        .done         (done)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:(1<<c_LOGSIZE)-1];
    always @(posedge clk) bram_dout <= mem[bram_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Expected outputs indexed by cycle
    logic       exp_valid [c_MAXC];
    logic       exp_done  [c_MAXC];
    logic       exp_play  [c_MAXC];
    int         exp_addr  [c_MAXC];
    logic [7:0] exp_out   [c_MAXC];

    // Abstract playback state
    bit m_play = 0;
    int m_pos  = 0;
    int m_vel  = 3;

    task automatic set_play(input int from, input logic v);
        for (int i = from; i < c_MAXC; i++) exp_play[i] = v;
    endtask

    task automatic set_addr(input int from, input int v);
        for (int i = from; i < c_MAXC; i++) exp_addr[i] = v;
    endtask

    task automatic set_out(input int from, input logic [7:0] v);
        for (int i = from; i < c_MAXC; i++) exp_out[i] = v;
    endtask

    function automatic int scale(input logic [7:0] raw, input int vel);
        int v;
        v = int'($signed(raw));
`ifdef DRUM_VELOCITY_EN
        begin
            int d;
            d = 1 << (3 - vel);
            if (v >= 0) return v / d;
            return -((-v + d - 1) / d);
        end
`else
        return v + 0 * vel;
`endif
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic model_trigger_idle(input int t, input int vel);
        m_play = 1;
        m_pos  = 0;
        m_vel  = vel;
        set_play(t + 1, 1'b1);
        set_addr(t + 1, 0);
    endtask

    task automatic check_lit(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // One ready strobe; optional trigger alongside it or retrigger 1/2 cycles later.
    task automatic do_sample(input bit trig_same, input int retrig_at, input int vel,
                             input int lit, input int gap);
        int t;
        int val;
        t = cyc;
        ready    = 1'b1;
        trigger  = trig_same;
        velocity = 2'(vel);
        if (trig_same) model_trigger_idle(t, vel);
        val = m_play ? scale(mem[m_pos], m_vel) : 0;
        exp_valid[t + 3] = 1'b1;
        set_out(t + 3, 8'(val));
        if (retrig_at != 0) begin
            m_vel = vel;
            m_pos = 0;
            m_play = 1;
            set_addr(t + 3, 0);
        end else if (m_play) begin
            m_pos++;
            if (m_pos == c_LEN) begin
                m_pos = 0;
                m_play = 0;
                exp_done[t + 3] = 1'b1;
                set_play(t + 3, 1'b0);
            end
            set_addr(t + 3, m_pos);
        end
        step;
        ready   = 1'b0;
        trigger = (retrig_at == 1);
        step;
        trigger = (retrig_at == 2);
        step;
        trigger = 1'b0;
        if (lit != c_NOLIT) check_lit("literal_sample", int'($signed(sample_out)), lit);
        repeat (gap) step;
    endtask

    task automatic do_trigger(input int vel);
        model_trigger_idle(cyc, vel);
        trigger  = 1'b1;
        velocity = 2'(vel);
        step;
        trigger = 1'b0;
        step;
    endtask

    task automatic do_reset;
        int t;
        t = cyc;
        reset = 1'b1;
        m_play = 0;
        m_pos  = 0;
        m_vel  = 3;
        set_play(t + 1, 1'b0);
        set_addr(t + 1, 0);
        set_out(t + 1, 8'h00);
        for (int i = t + 1; i < c_MAXC; i++) begin
            exp_valid[i] = 1'b0;
            exp_done[i]  = 1'b0;
        end
        step;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (cyc >= 2 && cyc < c_MAXC) begin
            checks += 6;
            if (sample_valid !== exp_valid[cyc]) begin
                errors++;
                $display("FAIL sample_valid @%0d: got %b expected %b", cyc, sample_valid, exp_valid[cyc]);
            end
            if (done !== exp_done[cyc]) begin
                errors++;
                $display("FAIL done @%0d: got %b expected %b", cyc, done, exp_done[cyc]);
            end
            if (playing !== exp_play[cyc]) begin
                errors++;
                $display("FAIL playing @%0d: got %b expected %b", cyc, playing, exp_play[cyc]);
            end
            if (sample_out !== exp_out[cyc]) begin
                errors++;
                $display("FAIL sample_out @%0d: got %h expected %h", cyc, sample_out, exp_out[cyc]);
            end
            if (int'(bram_addr) != exp_addr[cyc] || $isunknown(bram_addr)) begin
                errors++;
                $display("FAIL bram_addr @%0d: got %0d expected %0d", cyc, bram_addr, exp_addr[cyc]);
            end
            if (bram_we !== 1'b0) begin
                errors++;
                $display("FAIL bram_we @%0d: got %b expected 0", cyc, bram_we);
            end
        end
    end

    initial begin
        for (int i = 0; i < (1 << c_LOGSIZE); i++) mem[i] = 8'(i);
        for (int i = 0; i < c_MAXC; i++) begin
            exp_valid[i] = 1'b0;
            exp_done[i]  = 1'b0;
            exp_play[i]  = 1'b0;
            exp_addr[i]  = 0;
            exp_out[i]   = 8'h00;
        end
        reset = 1'b1;
        repeat (3) step;
        reset = 1'b0;
        repeat (4) step;

        // Idle strobes: silence
        for (int k = 0; k < 3; k++) do_sample(0, 0, 3, 0, 7);

        // Full playback of 4 samples
        do_trigger(3);
        do_sample(0, 0, 3, 0, 3);
        do_sample(0, 0, 3, 1, 3);
        do_sample(0, 0, 3, 2, 3);
        do_sample(0, 0, 3, 3, 0);
        check_lit("done_with_last", int'(done), 1);
        check_lit("playing_after_last", int'(playing), 0);
        repeat (3) step;
        do_sample(0, 0, 3, 0, 4);

        // Velocity attenuation of a negative sample
        mem[0] = 8'hC0;
        do_trigger(1);
`ifdef DRUM_VELOCITY_EN
        do_sample(0, 0, 1, -16, 3);
`else
        do_sample(0, 0, 1, -64, 3);
`endif
        for (int k = 0; k < 3; k++) do_sample(0, 0, 1, c_NOLIT, 3);
        mem[0] = 8'h00;

        // Retrigger during S_READ of address 2, then during S_CAPTURE
        do_trigger(3);
        do_sample(0, 0, 3, 0, 3);
        do_sample(0, 0, 3, 1, 3);
        do_sample(0, 1, 3, 2, 3);
        check_lit("no_done_on_retrigger", int'(done), 0);
        check_lit("retrigger_addr", int'(bram_addr), 0);
        do_sample(0, 0, 3, 0, 3);
        do_sample(0, 2, 3, 1, 3);
        for (int k = 0; k < 4; k++) do_sample(0, 0, 3, c_NOLIT, 3);

        // Trigger and ready in the same idle cycle
        mem[0] = 8'h55;
        do_sample(1, 0, 3, 85, 3);
        for (int k = 0; k < 3; k++) do_sample(0, 0, 3, c_NOLIT, 3);
        mem[0] = 8'h00;

        // Reset while positioned at address 2
        do_trigger(3);
        do_sample(0, 0, 3, 0, 3);
        do_sample(0, 0, 3, 1, 3);
        check_lit("addr_before_reset", int'(bram_addr), 2);
        do_reset;
        check_lit("playing_after_reset", int'(playing), 0);
        step;
        do_sample(0, 0, 3, 0, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
